// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Front-panel time-setting controller. Synchronises and
//               debounces the mode/inc buttons, runs RUN/SET_H/SET_M, edits
//               hours/minutes with auto-repeat, pulses load on exit and
//               drives the digit blink mask used while editing.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 12_500_000,
   parameter int BLINK_CYCLES    = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode_n,
   input  logic       btn_inc_n,
   input  logic [5:0] cur_hours,
   input  logic [5:0] cur_minutes,
   output logic [5:0] set_hours,
   output logic [5:0] set_minutes,
   output logic       load,
   output logic       hold,
   output logic [5:0] blink_mask
);

   // One shared counter width, sized for the largest period plus a spare bit.
   localparam int MAX_AB     = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int MAX_CYCLES = (MAX_AB > BLINK_CYCLES) ? MAX_AB : BLINK_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_SET_H = 2'd1;
   localparam logic [1:0] ST_SET_M = 2'd2;

   localparam logic [5:0] MASK_HOURS   = 6'b110000;
   localparam logic [5:0] MASK_MINUTES = 6'b001100;

   // Button index 0 is mode, index 1 is inc; both converted to active-high.
   logic [1:0] btn_pressed;
   assign btn_pressed = {~btn_inc_n, ~btn_mode_n};

   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             deb_q, deb_d;
      logic             press_q, press_d;
      logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

      // Count consecutive samples disagreeing with the debounced level; flip on the last one.
      always_comb begin
         sync1_d   = btn_pressed[gi];
         sync2_d   = sync1_q;
         deb_d     = deb_q;
         press_d   = 1'b0;
         deb_cnt_d = '0;
         if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
               deb_d   = sync2_q;
               press_d = sync2_q;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
      end

      // Synchroniser, debounced level and press-event registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            press_q   <= 1'b0;
            deb_cnt_q <= '0;
         end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            press_q   <= press_d;
            deb_cnt_q <= deb_cnt_d;
         end
      end
   end

   logic mode_press;
   logic inc_press;
   logic inc_held;
   assign mode_press = g_btn[0].press_q;
   assign inc_press  = g_btn[1].press_q;
   assign inc_held   = g_btn[1].deb_q;

   logic [1:0]       state_q, state_d;
   logic [5:0]       set_hours_q, set_hours_d;
   logic [5:0]       set_minutes_q, set_minutes_d;
   logic             load_q, load_d;
   logic             hold_q, hold_d;
   logic [5:0]       blink_mask_q, blink_mask_d;
   logic             rep_q, rep_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             phase_q, phase_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             inc_evt;
   logic             state_chg;

   // Mode/edit state machine; a mode press always beats a same-cycle inc event.
   always_comb begin
      state_d       = state_q;
      set_hours_d   = set_hours_q;
      set_minutes_d = set_minutes_q;
      load_d        = 1'b0;
      inc_evt       = (state_q != ST_RUN) && (inc_press || rep_q) && !mode_press;
      case (state_q)
         ST_RUN: begin
            if (mode_press) begin
               state_d       = ST_SET_H;
               set_hours_d   = (cur_hours > 6'd23) ? 6'd0 : cur_hours;
               set_minutes_d = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
            end
         end
         ST_SET_H: begin
            if (mode_press) begin
               state_d = ST_SET_M;
            end else if (inc_evt) begin
               set_hours_d = (set_hours_q == 6'd23) ? 6'd0 : set_hours_q + 6'd1;
            end
         end
         ST_SET_M: begin
            if (mode_press) begin
               state_d = ST_RUN;
               load_d  = 1'b1;
            end else if (inc_evt) begin
               set_minutes_d = (set_minutes_q == 6'd59) ? 6'd0 : set_minutes_q + 6'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      state_chg = (state_d != state_q);
   end

   // Auto-repeat timer, blink timer and registered output values.
   always_comb begin
      rep_d       = 1'b0;
      rep_cnt_d   = '0;
      phase_d     = 1'b0;
      blink_cnt_d = '0;
      hold_d      = (state_d != ST_RUN);
      if ((state_q != ST_RUN) && inc_held && !state_chg) begin
         if (rep_cnt_q == REP_LAST) begin
            rep_d = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end
      // Entering a set state or editing restarts the blink in the visible phase.
      if ((state_d != ST_RUN) && !state_chg && !inc_evt) begin
         if (blink_cnt_q == BLINK_LAST) begin
            phase_d = ~phase_q;
         end else begin
            phase_d     = phase_q;
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
      case (state_d)
         ST_SET_H: blink_mask_d = phase_d ? MASK_HOURS : 6'd0;
         ST_SET_M: blink_mask_d = phase_d ? MASK_MINUTES : 6'd0;
         default:  blink_mask_d = 6'd0;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         set_hours_q   <= 6'd0;
         set_minutes_q <= 6'd0;
         load_q        <= 1'b0;
         hold_q        <= 1'b0;
         blink_mask_q  <= 6'd0;
         rep_q         <= 1'b0;
         rep_cnt_q     <= '0;
         phase_q       <= 1'b0;
         blink_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         set_hours_q   <= set_hours_d;
         set_minutes_q <= set_minutes_d;
         load_q        <= load_d;
         hold_q        <= hold_d;
         blink_mask_q  <= blink_mask_d;
         rep_q         <= rep_d;
         rep_cnt_q     <= rep_cnt_d;
         phase_q       <= phase_d;
         blink_cnt_q   <= blink_cnt_d;
      end
   end

   assign set_hours   = set_hours_q;
   assign set_minutes = set_minutes_q;
   assign load        = load_q;
   assign hold        = hold_q;
   assign blink_mask  = blink_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Self-checking bench for time_set_ctrl with a behavioural
//               reference model and directed front-panel scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

   localparam int D = 4;
   localparam int R = 16;
   localparam int B = 8;

   localparam int M_RUN = 0;
   localparam int M_HRS = 1;
   localparam int M_MIN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode_n = 1'b1;
   logic       btn_inc_n = 1'b1;
   logic [5:0] cur_hours = 6'd0;
   logic [5:0] cur_minutes = 6'd0;
   logic [5:0] set_hours;
   logic [5:0] set_minutes;
   logic       load;
   logic       hold;
   logic [5:0] blink_mask;

   int total = 0;
   int bad = 0;

   time_set_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES(R),
      .BLINK_CYCLES(B)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_mode_n(btn_mode_n),
      .btn_inc_n(btn_inc_n),
      .cur_hours(cur_hours),
      .cur_minutes(cur_minutes),
      .set_hours(set_hours),
      .set_minutes(set_minutes),
      .load(load),
      .hold(hold),
      .blink_mask(blink_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_valid = 1'b0;
   int edge_no = 0;
   int m_state = M_RUN;
   int m_h = 0, m_m = 0, m_mask = 0;
   bit m_load = 1'b0, m_rep = 1'b0;
   int rep_anchor = 0, blink_anchor = 0;
   bit deb_mode = 1'b0, deb_inc = 1'b0, pr_mode = 1'b0, pr_inc = 1'b0;
   bit hist_mode[$];
   bit hist_inc[$];

   // True when the D samples the debouncer has fully absorbed all disagree with its level.
   function automatic bit window_flips(input bit q[$], input bit deb);
      bit r;
      int idx;
      bit v;
      r = 1'b1;
      for (int j = 2; j <= D + 1; j++) begin
         idx = q.size() - 1 - j;
         v = (idx >= 0) ? q[idx] : 1'b0;
         if (v == deb) r = 1'b0;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      int prev_state;
      bit mode_ev, inc_ev, chg, in_set, fm, fi;
      edge_no++;
      if (rst) begin
         m_valid = 1'b1;
         m_state = M_RUN; m_h = 0; m_m = 0; m_load = 1'b0; m_rep = 1'b0; m_mask = 0;
         rep_anchor = edge_no; blink_anchor = edge_no;
         deb_mode = 1'b0; deb_inc = 1'b0; pr_mode = 1'b0; pr_inc = 1'b0;
         hist_mode.delete(); hist_inc.delete();
      end else begin
         mode_ev = pr_mode;
         in_set = (m_state != M_RUN);
         inc_ev = in_set && (pr_inc || m_rep) && !mode_ev;
         prev_state = m_state;
         m_load = 1'b0;
         if (mode_ev) begin
            if (m_state == M_RUN) begin
               m_state = M_HRS;
               m_h = (cur_hours > 23) ? 0 : int'(cur_hours);
               m_m = (cur_minutes > 59) ? 0 : int'(cur_minutes);
            end else if (m_state == M_HRS) begin
               m_state = M_MIN;
            end else begin
               m_state = M_RUN;
               m_load = 1'b1;
            end
         end else if (inc_ev) begin
            if (m_state == M_HRS) m_h = (m_h + 1) % 24;
            else m_m = (m_m + 1) % 60;
         end
         chg = (prev_state != m_state);
         if (in_set && deb_inc && !chg) begin
            if (edge_no - rep_anchor == R) begin
               m_rep = 1'b1;
               rep_anchor = edge_no;
            end else begin
               m_rep = 1'b0;
            end
         end else begin
            m_rep = 1'b0;
            rep_anchor = edge_no;
         end
         if (chg || inc_ev) blink_anchor = edge_no;
         if (m_state == M_HRS && ((edge_no - blink_anchor) / B) % 2 == 1) m_mask = 48;
         else if (m_state == M_MIN && ((edge_no - blink_anchor) / B) % 2 == 1) m_mask = 12;
         else m_mask = 0;
         hist_mode.push_back(~btn_mode_n);
         hist_inc.push_back(~btn_inc_n);
         if (hist_mode.size() > D + 4) void'(hist_mode.pop_front());
         if (hist_inc.size() > D + 4) void'(hist_inc.pop_front());
         fm = window_flips(hist_mode, deb_mode);
         fi = window_flips(hist_inc, deb_inc);
         if (fm) deb_mode = ~deb_mode;
         if (fi) deb_inc = ~deb_inc;
         pr_mode = fm && deb_mode;
         pr_inc = fi && deb_inc;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_set_hours", set_hours, m_h);
         check("cyc_set_minutes", set_minutes, m_m);
         check("cyc_load", load, m_load);
         check("cyc_hold", hold, (m_state != M_RUN) ? 1 : 0);
         check("cyc_blink_mask", blink_mask, m_mask);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tap(input bit inc);
      if (inc) btn_inc_n = 1'b0;
      else btn_mode_n = 1'b0;
      step(8);
      btn_inc_n = 1'b1;
      btn_mode_n = 1'b1;
      step(12);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int found;
      int nchg;
      int tchg[4];
      int prev;

      // 1. reset
      step(3);
      check("rst_hours", set_hours, 0);
      check("rst_minutes", set_minutes, 0);
      check("rst_load", load, 0);
      check("rst_hold", hold, 0);
      check("rst_mask", blink_mask, 0);
      rst = 1'b0;
      step(2);

      // 2. bounce rejection
      cur_hours = 6'd5; cur_minutes = 6'd10;
      tap(0);
      check("enter_hours", set_hours, 5);
      check("enter_hold", hold, 1);
      repeat (5) begin
         btn_inc_n = 1'b0; step(3);
         btn_inc_n = 1'b1; step(2);
      end
      step(10);
      check("bounce_hours", set_hours, 5);
      btn_inc_n = 1'b0; step(10);
      btn_inc_n = 1'b1; step(12);
      check("steady_hours", set_hours, 6);
      tap(0); tap(0);
      check("exit_hours", set_hours, 6);
      check("exit_hold", hold, 0);

      // 3. full edit sequence with wrap
      cur_hours = 6'd22; cur_minutes = 6'd58;
      tap(0);
      check("edit_hold", hold, 1);
      check("edit_hours", set_hours, 22);
      check("edit_minutes", set_minutes, 58);
      tap(1);
      check("inc_h23", set_hours, 23);
      tap(1);
      check("wrap_h0", set_hours, 0);
      tap(0); tap(1);
      check("inc_m59", set_minutes, 59);
      tap(1);
      check("wrap_m0", set_minutes, 0);
      btn_mode_n = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(negedge clk);
         if (load) found = 1;
      end
      check("load_seen", found, 1);
      check("load_hours", set_hours, 0);
      check("load_minutes", set_minutes, 0);
      check("load_hold", hold, 0);
      @(negedge clk);
      check("load_one_cycle", load, 0);
      btn_mode_n = 1'b1;
      step(12);

      // 4. clamp on capture
      cur_hours = 6'd24; cur_minutes = 6'd60;
      tap(0);
      check("clamp_hours", set_hours, 0);
      check("clamp_minutes", set_minutes, 0);
      tap(0); tap(0);

      // 5. auto-repeat
      cur_hours = 6'd3; cur_minutes = 6'd10;
      tap(0); tap(0);
      check("rep_start", set_minutes, 10);
      btn_inc_n = 1'b0;
      prev = set_minutes;
      nchg = 0;
      for (int i = 0; i < 56; i++) begin
         @(negedge clk);
         if (set_minutes != prev) begin
            if (nchg < 4) tchg[nchg] = i;
            nchg++;
            prev = set_minutes;
         end
      end
      btn_inc_n = 1'b1;
      check("rep_count", nchg, 4);
      check("rep_value", set_minutes, 14);
      if (nchg == 4) begin
         check("rep_gap1", tchg[1] - tchg[0], 16);
         check("rep_gap2", tchg[2] - tchg[1], 16);
         check("rep_gap3", tchg[3] - tchg[2], 16);
      end
      step(30);
      check("rep_release", set_minutes, 14);
      tap(0);

      // 6a. blink after entering SET_H
      cur_hours = 6'd7; cur_minutes = 6'd20;
      btn_mode_n = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(negedge clk);
         if (hold) found = 1;
      end
      check("blink_entry", found, 1);
      btn_mode_n = 1'b1;
      for (int k = 0; k < 32; k++) begin
         check("blink_phase", blink_mask, (((k / 8) % 2) == 1) ? 48 : 0);
         @(negedge clk);
      end

      // 6b. simultaneous mode and inc
      step(5);
      btn_mode_n = 1'b0; btn_inc_n = 1'b0;
      step(8);
      btn_mode_n = 1'b1; btn_inc_n = 1'b1;
      step(12);
      check("simul_hours", set_hours, 7);
      tap(1);
      check("simul_in_setm", set_minutes, 21);
      check("simul_hours_kept", set_hours, 7);

      // 6c. reset in SET_M
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_hold", hold, 0);
      check("mid_rst_hours", set_hours, 0);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (load) found = 1;
      end
      check("mid_rst_no_load", found, 0);

      // button held through reset is a fresh press D+2 cycles later
      rst = 1'b1; btn_mode_n = 1'b0;
      step(2);
      rst = 1'b0;
      step(6);
      check("held_rst_early", hold, 0);
      step(1);
      check("held_rst_press", hold, 1);
      check("held_rst_hours", set_hours, 7);
      btn_mode_n = 1'b1;
      step(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
